// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by an OVERSAMPLE x baud tick strobe.
// Synchronises rx, validates the start bit at mid-bit and samples each data/stop bit at its centre.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud8_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [1:0]           rst_sync_r;
    logic                 rst_n_s;
    logic [1:0]           rx_sync_r;
    logic                 rx_s;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 busy_r;
    logic                 at_half_s;
    logic                 at_full_s;
    logic                 cnt_clr_s;
    logic                 cnt_inc_s;
    logic                 idx_clr_s;
    logic                 shift_en_s;
    logic                 valid_set_s;
    logic                 err_set_s;

    // Reset synchroniser: asserts immediately, releases two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Two-flop rx synchroniser, preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
        end
    end

    assign rx_s      = rx_sync_r[1];
    assign at_half_s = (cnt_r == CNT_HALF);
    assign at_full_s = (cnt_r == CNT_FULL);

    // State register.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the FSM only moves on baud ticks.
    always_comb begin
        state_nxt_s = state_r;
        if (baud8_tick) begin
            case (state_r)
                ST_IDLE:  state_nxt_s = rx_s ? ST_IDLE : ST_START;
                ST_START: begin
                    if (at_half_s) begin
                        state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (at_full_s && (bit_idx_r == IDX_LAST)) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (at_full_s) begin
                        state_nxt_s = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                ST_BREAK: state_nxt_s = rx_s ? ST_IDLE : ST_BREAK;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Per-state datapath controls, decoded only on ticks.
    always_comb begin
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        idx_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        valid_set_s = 1'b0;
        err_set_s   = 1'b0;
        if (baud8_tick) begin
            case (state_r)
                ST_IDLE: cnt_clr_s = ~rx_s;
                ST_START: begin
                    cnt_clr_s = at_half_s;
                    cnt_inc_s = ~at_half_s;
                    idx_clr_s = at_half_s & ~rx_s;
                end
                ST_DATA: begin
                    cnt_clr_s  = at_full_s;
                    cnt_inc_s  = ~at_full_s;
                    shift_en_s = at_full_s;
                end
                ST_STOP: begin
                    cnt_clr_s   = at_full_s;
                    cnt_inc_s   = ~at_full_s;
                    valid_set_s = at_full_s & rx_s;
                    err_set_s   = at_full_s & ~rx_s;
                end
                ST_BREAK: cnt_clr_s = 1'b0;
                default:  cnt_clr_s = 1'b1;
            endcase
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    // Tick counter, bit index and shift register (LSB-first, shifted in at the MSB).
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
        end else begin
            if (cnt_clr_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // Index saturates at the last bit so it never wraps past its compare value.
            if (idx_clr_s) begin
                bit_idx_r <= {IDX_W{1'b0}};
            end else if (shift_en_s && (bit_idx_r != IDX_LAST)) begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
            if (shift_en_s) begin
                shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            end
        end
    end

    // Registered outputs: single-cycle pulses, held data and busy.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rx_data_r   <= {DATA_BITS{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= valid_set_s;
            frame_err_r <= err_set_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (valid_set_s) begin
                rx_data_r <= shift_r;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random tick spacing and data, checked against a frame-level model.
module tb_uart_rx;

    localparam int DB = 8;
    localparam int OS = 8;
    localparam int STOP_OFS = OS / 2 + OS * (DB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          baud8_tick;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .baud8_tick(baud8_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    int            tick_idx = 0;
    logic [DB-1:0] obs_data[$];
    int            obs_tick[$];
    logic [DB-1:0] exp_data[$];
    int            exp_tick[$];
    int            n_ferr = 0;
    int            ferr_tick = 0;
    int            exp_ferr_tick = 0;
    int            n_late = 0;
    int            n_overlap = 0;
    logic [DB-1:0] last_good = '0;

    // Output monitor: pulses must follow a tick by exactly one clock.
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            obs_data.push_back(rx_data);
            obs_tick.push_back(tick_idx);
            if (!baud8_tick) n_late++;
        end
        if (frame_err) begin
            n_ferr++;
            ferr_tick = tick_idx;
            if (!baud8_tick) n_late++;
        end
        if (rx_valid && frame_err) n_overlap++;
    end

    task automatic tick_once(input logic v);
        @(negedge clk);
        rx = v;
        baud8_tick = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        baud8_tick = 1'b1;
        tick_idx++;
        @(negedge clk);
        baud8_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick_once(1'b1);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input int stop_ticks);
        int t0;
        t0 = tick_idx + 1;
        if (stop_v) begin
            exp_data.push_back(d);
            exp_tick.push_back(t0 + STOP_OFS);
            last_good = d;
        end else begin
            exp_ferr_tick = t0 + STOP_OFS;
        end
        repeat (OS) tick_once(1'b0);
        for (int i = 0; i < DB; i++) repeat (OS) tick_once(d[i]);
        repeat (stop_ticks) tick_once(stop_v);
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_tick.delete();
        exp_data.delete();
        exp_tick.delete();
        n_ferr = 0;
        n_late = 0;
        n_overlap = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx = 1'b1;
        baud8_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_obs();
        last_good = '0;
        idle(100);
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++;
        if (rx_data !== last_good) begin n_bad++; $display("FAIL reset rx_data: got %h want %h", rx_data, last_good); end
        n_vec++;
        if (obs_data.size() !== 0 || n_ferr !== 0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset pulses: valid %0d ferr %0d want 0 0", obs_data.size(), n_ferr);
        end
    endtask

    task automatic test_single();
        clear_obs();
        send_frame(8'hA5, 1'b1, OS);
        idle(2);
        n_vec++;
        if (obs_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL single count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_tick[i] !== exp_tick[i]) begin
                n_bad++;
                $display("FAIL single frame %0d: got %h@tick%0d want %h@tick%0d", i, obs_data[i], obs_tick[i], exp_data[i], exp_tick[i]);
            end
        end
        n_vec++;
        if (n_late !== 0 || n_overlap !== 0 || n_ferr !== 0) begin
            n_bad++; $display("FAIL single pulse shape: late %0d overlap %0d ferr %0d want 0", n_late, n_overlap, n_ferr);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(8'h3C, 1'b1, OS);
        send_frame(8'hFF, 1'b1, OS);
        idle(2);
        n_vec++;
        if (obs_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL b2b count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_tick[i] !== exp_tick[i]) begin
                n_bad++;
                $display("FAIL b2b frame %0d: got %h@tick%0d want %h@tick%0d", i, obs_data[i], obs_tick[i], exp_data[i], exp_tick[i]);
            end
        end
        n_vec++;
        if (n_late !== 0 || n_overlap !== 0 || n_ferr !== 0) begin
            n_bad++; $display("FAIL b2b pulse shape: late %0d overlap %0d ferr %0d want 0", n_late, n_overlap, n_ferr);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        idle(3);
        tick_once(1'b0);
        tick_once(1'b0);
        n_vec++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch detect busy: got %b want 1", busy); end
        idle(5);
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch busy: got %b want 0", busy); end
        n_vec++;
        if (obs_data.size() !== 0 || n_ferr !== 0) begin
            n_bad++; $display("FAIL glitch pulses: valid %0d ferr %0d want 0 0", obs_data.size(), n_ferr);
        end
    endtask

    task automatic test_break();
        logic [DB-1:0] prior;
        clear_obs();
        prior = last_good;
        send_frame(8'h55, 1'b0, OS * 20);
        n_vec++;
        if (n_ferr !== 1 || obs_data.size() !== 0) begin
            n_bad++; $display("FAIL break pulses: ferr %0d valid %0d want 1 0", n_ferr, obs_data.size());
        end
        n_vec++;
        if (ferr_tick !== exp_ferr_tick || n_late !== 0) begin
            n_bad++; $display("FAIL break ferr timing: got tick%0d late %0d want tick%0d late 0", ferr_tick, n_late, exp_ferr_tick);
        end
        n_vec++;
        if (rx_data !== prior) begin n_bad++; $display("FAIL break rx_data: got %h want %h", rx_data, prior); end
        n_vec++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL break busy held: got %b want 1", busy); end
        idle(1);
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL break release busy: got %b want 0", busy); end
        idle(2);
        clear_obs();
        send_frame(8'h12, 1'b1, OS);
        idle(2);
        n_vec++;
        if (obs_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL after-break count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_tick[i] !== exp_tick[i]) begin
                n_bad++;
                $display("FAIL after-break frame %0d: got %h@tick%0d want %h@tick%0d", i, obs_data[i], obs_tick[i], exp_data[i], exp_tick[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d;
        clear_obs();
        d = 8'hC3;
        repeat (OS) tick_once(1'b0);
        for (int i = 0; i < 4; i++) repeat (OS) tick_once(d[i]);
        repeat (3) tick_once(d[4]);
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        last_good = '0;
        idle(10);
        n_vec++;
        if (rx_data !== last_good) begin n_bad++; $display("FAIL mid-reset rx_data: got %h want %h", rx_data, last_good); end
        n_vec++;
        if (obs_data.size() !== 0 || n_ferr !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid-reset state: valid %0d ferr %0d busy %b want 0 0 0", obs_data.size(), n_ferr, busy);
        end
        send_frame(8'h81, 1'b1, OS);
        idle(2);
        n_vec++;
        if (obs_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL mid-reset count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_tick[i] !== exp_tick[i]) begin
                n_bad++;
                $display("FAIL mid-reset frame %0d: got %h@tick%0d want %h@tick%0d", i, obs_data[i], obs_tick[i], exp_data[i], exp_tick[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        clear_obs();
        for (int k = 0; k < 8; k++) begin
            d = DB'($urandom);
            send_frame(d, 1'b1, OS);
            idle($urandom_range(0, 3));
        end
        idle(2);
        n_vec++;
        if (obs_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL random count: got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_vec++;
            if (obs_data[i] !== exp_data[i] || obs_tick[i] !== exp_tick[i]) begin
                n_bad++;
                $display("FAIL random frame %0d: got %h@tick%0d want %h@tick%0d", i, obs_data[i], obs_tick[i], exp_data[i], exp_tick[i]);
            end
        end
        n_vec++;
        if (rx_data !== last_good || n_late !== 0 || n_overlap !== 0 || n_ferr !== 0) begin
            n_bad++;
            $display("FAIL random hold: rx_data %h late %0d overlap %0d ferr %0d want %h 0 0 0", rx_data, n_late, n_overlap, n_ferr, last_good);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1-style UART receiver that consumes the baud8_tick strobe from the team's 8x-oversampling baud generator.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each data bit at its centre.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.
- Sits between the pad-level rx pin and the receive FIFO / command parser.

Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first; legal range 5..8.
- OVERSAMPLE, 8: baud8_tick pulses per bit period; must be even and at least 4; must match the baud generator.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- baud8_tick  input  1  one-clk strobe at OVERSAMPLE x BAUD, from the baud generator
- rx  input  1  serial line, asynchronous, idle high
- rx_data  output  DATA_BITS  last correctly framed byte; held until the next good frame
- rx_valid  output  1  one-clk pulse: rx_data has just updated
- frame_err  output  1  one-clk pulse: stop bit sampled low
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert into the clk domain):
  - state=IDLE; tick counter and bit index cleared; shift register cleared.
  - rx synchroniser flops preset to 1.
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
- rx passes through a 2-FF synchroniser (rx_s). All decisions use rx_s, so line-to-FSM latency is 2 clk.
- The FSM advances only in clk cycles where baud8_tick=1. With baud8_tick=0, all state, counters and the shift register hold.
- IDLE:
  - On a tick with rx_s=0: go to START, cnt<=0.
- START:
  - On each tick, if cnt==OVERSAMPLE/2-1, check rx_s:
    - rx_s=0: go to DATA, cnt<=0, bit_idx<=0.
    - rx_s=1 (glitch / false start): go to IDLE; no output pulse.
  - Otherwise cnt<=cnt+1.
  - Net effect: start is validated OVERSAMPLE/2 ticks after detection, i.e. at mid-bit.
- DATA:
  - On each tick with cnt==OVERSAMPLE-1: shift rx_s in at the MSB (shift right, so the first received bit ends at bit 0), cnt<=0, bit_idx<=bit_idx+1.
    - When bit_idx==DATA_BITS-1: go to STOP.
  - Otherwise cnt<=cnt+1.
- STOP:
  - On the tick with cnt==OVERSAMPLE-1, sample rx_s:
    - rx_s=1: rx_data<=shift register, rx_valid=1 in the next clk cycle, go to IDLE.
    - rx_s=0: frame_err=1 in the next clk cycle, rx_data unchanged, go to BREAK.
  - Otherwise cnt<=cnt+1.
- BREAK:
  - Wait for rx_s=1 on a tick, then go to IDLE.
  - This stops a held-low line (break condition) from being decoded as repeated 0x00 frames.
- Output timing:
  - rx_valid and frame_err are registered, exactly one clk wide, and mutually exclusive.
  - Both clear on the following cycle regardless of baud8_tick.
  - Latency: the stop-bit sample tick plus 1 clk gives the valid pulse.
- Back-to-back frames: a start bit detected on the first tick after returning to IDLE is accepted; no idle gap is required.
- Reset mid-frame: the frame is abandoned immediately. No pulse is produced and rx_data returns to 0.
- Widths:
  - cnt is clog2(OVERSAMPLE) bits, bit_idx is clog2(DATA_BITS) bits.
  - No wrap occurs beyond the compare values.

Test Plan:
- Reset, then rx=1 with ticks running for 100 ticks: busy=0, rx_valid=0, frame_err=0, rx_data=0.
- Drive 0xA5 at 8 ticks/bit (start, 1,0,1,0,0,1,0,1, stop): exactly one rx_valid pulse with rx_data=8'hA5; valid arrives 1 clk after the stop-bit mid-sample tick.
- Drive 0x3C immediately followed by 0xFF with no idle gap: two rx_valid pulses, data 8'h3C then 8'hFF.
- Drive a 2-tick low glitch on rx: START aborts to IDLE, no pulses, busy returns to 0 within 5 ticks.
- Drive 0x55 with the stop bit held low for 20 bit times: one frame_err pulse, no rx_valid, rx_data keeps its prior value, busy stays high until rx returns high. Then send 0x12: rx_valid with 8'h12.
- Assert rst=0 during data bit 4 of a frame, then release: no pulses and rx_data=0. The next clean 0x81 frame is received correctly.
